adder_float: RTL and testbench

ADDER_FLOAT -- requirements
Module: adder_float

---
 rtl/adder_float.sv | 223 ++++++++++++++++++++++
 tb/tb_adder_float.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_float.sv
// adder_float: pipelined floating-point adder for {sign, biased exponent, fraction} operands.
// Operands are registered on entry, then pass through align, add/subtract and
// normalize/round stages, so a result appears three edges after its operands are sampled.
// Denormal inputs are flushed to zero; Inf/NaN inputs and overflow raise exce_out.
module adder_float #(
    parameter int WIDTH       = 32,
    parameter int WIDTH_exp   = 8,
    parameter int WIDTH_mat   = 23,
    parameter int WIDTH_round = 30
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    input  logic             exce_in,
    output logic             exce_out,
    output logic [WIDTH-1:0] result
);

    // Guard bits below the fraction; the lowest one collects sticky information.
    localparam int GRD = WIDTH_round - WIDTH_mat - 2;
    // Exponent working width: one bit of headroom plus a sign bit for underflow detection.
    localparam int EW  = WIDTH_exp + 2;
    localparam int LW  = $clog2(WIDTH_round);
    // Normalized magnitude width (carry position dropped).
    localparam int NW  = WIDTH_round - 1;
    localparam logic [WIDTH_exp-1:0] EXP_ONES = '1;

    // ---------------- operand capture ----------------
    logic [WIDTH-1:0] in_a_reg, in_b_reg;
    logic             in_exce_reg;

    // Sample the operand pair and upstream exception flag every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            in_a_reg    <= '0;
            in_b_reg    <= '0;
            in_exce_reg <= 1'b0;
        end else begin
            in_a_reg    <= OP1;
            in_b_reg    <= OP2;
            in_exce_reg <= exce_in;
        end
    end

    // ---------------- stage 1: unpack, swap, align ----------------
    logic                   sign_a, sign_b, zero_a, zero_b, spec_a, spec_b, a_first;
    logic [WIDTH_exp-1:0]   exp_a, exp_b, exp_l, exp_s, exp_diff;
    logic [WIDTH-2:0]       key_a, key_b;
    logic [WIDTH_round-1:0] mant_a, mant_b, mant_l, mant_s, mant_s_aligned, shift_mask;
    logic                   sign_l, sign_s;

    assign sign_a = in_a_reg[WIDTH-1];
    assign sign_b = in_b_reg[WIDTH-1];
    assign exp_a  = in_a_reg[WIDTH-2 -: WIDTH_exp];
    assign exp_b  = in_b_reg[WIDTH-2 -: WIDTH_exp];
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign spec_a = (exp_a == EXP_ONES);
    assign spec_b = (exp_b == EXP_ONES);
    // Magnitude keys with denormals flushed to zero; ties keep OP1 as the larger.
    assign key_a   = zero_a ? '0 : in_a_reg[WIDTH-2:0];
    assign key_b   = zero_b ? '0 : in_b_reg[WIDTH-2:0];
    assign a_first = (key_a >= key_b);
    // Extended mantissa: {carry, hidden, fraction, guard}; a zero operand has no hidden bit.
    assign mant_a = {1'b0, ~zero_a, in_a_reg[WIDTH_mat-1:0] & {WIDTH_mat{~zero_a}}, {GRD{1'b0}}};
    assign mant_b = {1'b0, ~zero_b, in_b_reg[WIDTH_mat-1:0] & {WIDTH_mat{~zero_b}}, {GRD{1'b0}}};
    assign exp_diff = exp_l - exp_s;

    // Order the operands so the larger magnitude comes first.
    always_comb begin
        if (a_first) begin
            sign_l = sign_a; sign_s = sign_b; exp_l = exp_a; exp_s = exp_b;
            mant_l = mant_a; mant_s = mant_b;
        end else begin
            sign_l = sign_b; sign_s = sign_a; exp_l = exp_b; exp_s = exp_a;
            mant_l = mant_b; mant_s = mant_a;
        end
    end

    // Right-shift the smaller mantissa, folding every shifted-out bit into the sticky LSB.
    always_comb begin
        shift_mask     = ~({WIDTH_round{1'b1}} << exp_diff);
        mant_s_aligned = mant_s >> exp_diff;
        if (int'(exp_diff) >= WIDTH_round)
            mant_s_aligned = {{(WIDTH_round-1){1'b0}}, |mant_s};
        else
            mant_s_aligned[0] = mant_s_aligned[0] | (|(mant_s & shift_mask));
    end

    logic                   s1_sign_l_reg, s1_sign_s_reg, s1_special_reg, s1_special_sign_reg;
    logic                   s1_bypass_reg, s1_exce_reg;
    logic [WIDTH_exp-1:0]   s1_exp_reg;
    logic [WIDTH_round-1:0] s1_mant_l_reg, s1_mant_s_reg;
    logic [WIDTH-1:0]       s1_bypass_val_reg;

    // Stage-1 register: aligned magnitudes plus the special/zero side paths.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_sign_l_reg <= 1'b0; s1_sign_s_reg <= 1'b0; s1_exp_reg <= '0;
            s1_mant_l_reg <= '0; s1_mant_s_reg <= '0;
            s1_special_reg <= 1'b0; s1_special_sign_reg <= 1'b0;
            s1_bypass_reg <= 1'b0; s1_bypass_val_reg <= '0; s1_exce_reg <= 1'b0;
        end else begin
            s1_sign_l_reg       <= sign_l;
            s1_sign_s_reg       <= sign_s;
            s1_exp_reg          <= exp_l;
            s1_mant_l_reg       <= mant_l;
            s1_mant_s_reg       <= mant_s_aligned;
            s1_special_reg      <= spec_a | spec_b;
            s1_special_sign_reg <= spec_a ? sign_a : sign_b;
            s1_bypass_reg       <= zero_a | zero_b;
            s1_bypass_val_reg   <= (zero_a & zero_b) ? '0 : (zero_a ? in_b_reg : in_a_reg);
            s1_exce_reg         <= in_exce_reg;
        end
    end

    // ---------------- stage 2: add or subtract magnitudes ----------------
    logic [WIDTH_round-1:0] sum_next;
    assign sum_next = (s1_sign_l_reg == s1_sign_s_reg) ? (s1_mant_l_reg + s1_mant_s_reg)
                                                       : (s1_mant_l_reg - s1_mant_s_reg);

    logic                   s2_sign_reg, s2_special_reg, s2_special_sign_reg, s2_bypass_reg, s2_exce_reg;
    logic [WIDTH_exp-1:0]   s2_exp_reg;
    logic [WIDTH_round-1:0] s2_sum_reg;
    logic [WIDTH-1:0]       s2_bypass_val_reg;

    // Stage-2 register: raw sum; result sign follows the larger operand.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_sign_reg <= 1'b0; s2_exp_reg <= '0; s2_sum_reg <= '0;
            s2_special_reg <= 1'b0; s2_special_sign_reg <= 1'b0;
            s2_bypass_reg <= 1'b0; s2_bypass_val_reg <= '0; s2_exce_reg <= 1'b0;
        end else begin
            s2_sign_reg         <= s1_sign_l_reg;
            s2_exp_reg          <= s1_exp_reg;
            s2_sum_reg          <= sum_next;
            s2_special_reg      <= s1_special_reg;
            s2_special_sign_reg <= s1_special_sign_reg;
            s2_bypass_reg       <= s1_bypass_reg;
            s2_bypass_val_reg   <= s1_bypass_val_reg;
            s2_exce_reg         <= s1_exce_reg;
        end
    end

    // ---------------- stage 3: normalize, round, pack ----------------
    logic [LW-1:0]        lzc;
    logic [EW-1:0]        exp_base, exp_norm, exp_fin;
    logic [NW-1:0]        norm;
    logic [WIDTH_mat:0]   mant_keep;
    logic [WIDTH_mat+1:0] mant_rnd;
    logic [WIDTH_mat-1:0] frac_fin;
    logic                 round_up, underflow, overflow;
    logic [WIDTH-1:0]     result_next;
    logic                 exce_next;

    assign exp_base = {2'b00, s2_exp_reg};

    // Leading-zero count measured from the hidden-bit position.
    always_comb begin
        lzc = '0;
        for (int i = 0; i < WIDTH_round - 1; i++)
            if (s2_sum_reg[i]) lzc = LW'(WIDTH_round - 2 - i);
    end

    // Bring the leading one to the hidden position and adjust the exponent.
    always_comb begin
        if (s2_sum_reg[WIDTH_round-1]) begin
            norm     = s2_sum_reg[WIDTH_round-1:1];
            norm[0]  = s2_sum_reg[1] | s2_sum_reg[0];
            exp_norm = exp_base + EW'(1);
        end else begin
            norm     = NW'(s2_sum_reg << lzc);
            exp_norm = exp_base - EW'(lzc);
        end
    end

    assign mant_keep = norm[NW-1 -: WIDTH_mat+1];
    assign round_up  = norm[GRD-1] & ((|norm[GRD-2:0]) | mant_keep[0]);
    assign mant_rnd  = {1'b0, mant_keep} + (WIDTH_mat+2)'(round_up);

    // Round to nearest even; a carry out of the mantissa bumps the exponent.
    always_comb begin
        exp_fin  = exp_norm;
        frac_fin = mant_rnd[WIDTH_mat-1:0];
        if (mant_rnd[WIDTH_mat+1]) begin
            exp_fin  = exp_norm + EW'(1);
            frac_fin = mant_rnd[WIDTH_mat:1];
        end
    end

    assign underflow = exp_fin[EW-1] || (exp_fin == '0);
    assign overflow  = !underflow && (exp_fin >= {2'b00, EXP_ONES});

    // Pick the final word: specials, zero pass-through, cancellation/underflow, overflow, normal.
    always_comb begin
        result_next = {s2_sign_reg, exp_fin[WIDTH_exp-1:0], frac_fin};
        exce_next   = s2_exce_reg;
        if (s2_special_reg) begin
            result_next = {s2_special_sign_reg, EXP_ONES, {WIDTH_mat{1'b0}}};
            exce_next   = 1'b1;
        end else if (s2_bypass_reg) begin
            result_next = s2_bypass_val_reg;
        end else if ((s2_sum_reg == '0) || underflow) begin
            result_next = '0;
        end else if (overflow) begin
            result_next = {s2_sign_reg, EXP_ONES, {WIDTH_mat{1'b0}}};
            exce_next   = 1'b1;
        end
    end

    // Output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            result   <= '0;
            exce_out <= 1'b0;
        end else begin
            result   <= result_next;
            exce_out <= exce_next;
        end
    end

endmodule

// File: tb/tb_adder_float.sv
// Testbench for adder_float: reset behaviour, directed vectors (isolated and back-to-back)
// and a randomized stream checked against an exact-arithmetic reference model.
module tb_adder_float;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] OP1 = '0;
    logic [31:0] OP2 = '0;
    logic        exce_in = 1'b0;
    logic        exce_out;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    adder_float #(.WIDTH(32), .WIDTH_exp(8), .WIDTH_mat(23), .WIDTH_round(30)) dut (
        .CLK(CLK), .RST(RST), .OP1(OP1), .OP2(OP2),
        .exce_in(exce_in), .exce_out(exce_out), .result(result)
    );

    always #5 CLK = ~CLK;

    localparam int ND = 17;
    localparam int NR = 300;
    logic [31:0] d_a[ND], d_b[ND], d_r[ND];
    logic        d_ei[ND], d_eo[ND];
    logic [31:0] r_a[NR], r_b[NR];
    logic        r_ei[NR];

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic e);
        OP1 = a; OP2 = b; exce_in = e;
    endtask

    task automatic set_dir(input int k, input logic [31:0] a, input logic [31:0] b, input logic ei,
                           input logic [31:0] r, input logic eo);
        d_a[k] = a; d_b[k] = b; d_ei[k] = ei; d_r[k] = r; d_eo[k] = eo;
    endtask

    // Exact sum of the two decoded values, then a single round-to-nearest-even to 24 bits.
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic ein);
        logic [319:0] ma, mb, mag, q, rem, half, one;
        int ea, eb, emin, p, k, e;
        logic s;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {1'b1, (ea == 255) ? a[31] : b[31], 8'hFF, 23'd0};
        if (ea == 0 && eb == 0) return {ein, 32'd0};
        if (ea == 0) return {ein, b};
        if (eb == 0) return {ein, a};
        emin = (ea < eb) ? ea : eb;
        ma = {296'd0, 1'b1, a[22:0]} << (ea - emin);
        mb = {296'd0, 1'b1, b[22:0]} << (eb - emin);
        if (a[31] == b[31]) begin mag = ma + mb; s = a[31]; end
        else if (ma >= mb)  begin mag = ma - mb; s = a[31]; end
        else                begin mag = mb - ma; s = b[31]; end
        if (mag == '0) return {ein, 32'd0};
        p = 0;
        for (int i = 0; i < 320; i++) if (mag[i]) p = i;
        e = emin + p - 23;
        one = 320'd1;
        if (p > 23) begin
            k    = p - 23;
            q    = mag >> k;
            rem  = mag & ((one << k) - one);
            half = one << (k - 1);
            if (rem > half || (rem == half && q[0])) q = q + one;
            if (q[24]) begin q = q >> 1; e = e + 1; end
        end else begin
            q = mag << (23 - p);
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (e <= 0) return {ein, 32'd0};
        return {ein, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input int base);
        int e, sel;
        sel = int'($urandom_range(0, 19));
        if (sel == 0)      e = 0;
        else if (sel == 1) e = 255;
        else if (sel == 2) e = 254;
        else if (sel == 3) e = 1;
        else begin
            e = base + int'($urandom_range(0, 64)) - 32;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end
        return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
    endfunction

    task automatic test_reset;
        RST = 1'b1;
        drive(32'h3F800000, 32'h3F800000, 1'b1);
        repeat (3) begin @(posedge CLK); #1; end
        checks++;
        if (result !== 32'h0 || exce_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: result %h exce %b, required 00000000 exce 0", result, exce_out);
        end
        RST = 1'b0;
        drive(32'h3F600000, 32'h3F700000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (i == 0) drive(32'h0, 32'h0, 1'b0);
            checks++;
            if (i < 3) begin
                if (result !== 32'h0 || exce_out !== 1'b0) begin
                    errors++;
                    $display("FAIL pre_valid[%0d]: result %h exce %b, required 00000000 exce 0", i, result, exce_out);
                end
            end else if (result !== 32'h3FE80000 || exce_out !== 1'b0) begin
                errors++;
                $display("FAIL first_valid: result %h exce %b, required 3fe80000 exce 0", result, exce_out);
            end
        end
        drive(32'h43E00000, 32'h41E00000, 1'b1);
        @(posedge CLK); #1;
        drive(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        drive(32'h0, 32'h0, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (result !== 32'h0 || exce_out !== 1'b0) begin
                errors++;
                $display("FAIL flush[%0d]: result %h exce %b, required 00000000 exce 0", i, result, exce_out);
            end
        end
    endtask

    task automatic test_directed;
        for (int k = 0; k < ND; k++) begin
            drive(d_a[k], d_b[k], d_ei[k]);
            @(posedge CLK); #1;
            drive(32'h0, 32'h0, 1'b0);
            repeat (2) begin @(posedge CLK); #1; end
            checks++;
            if (result !== 32'h0 || exce_out !== 1'b0) begin
                errors++;
                $display("FAIL latency[%0d]: result %h exce %b, required 00000000 exce 0 before edge N+3", k, result, exce_out);
            end
            @(posedge CLK); #1;
            checks++;
            if (result !== d_r[k] || exce_out !== d_eo[k]) begin
                errors++;
                $display("FAIL directed[%0d] %h+%h: result %h exce %b, required %h exce %b",
                         k, d_a[k], d_b[k], result, exce_out, d_r[k], d_eo[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < ND + 3; i++) begin
            if (i < ND) drive(d_a[i], d_b[i], d_ei[i]); else drive(32'h0, 32'h0, 1'b0);
            @(posedge CLK); #1;
            if (i >= 3) begin
                checks++;
                if (result !== d_r[i-3] || exce_out !== d_eo[i-3]) begin
                    errors++;
                    $display("FAIL back_to_back[%0d]: result %h exce %b, required %h exce %b",
                             i - 3, result, exce_out, d_r[i-3], d_eo[i-3]);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [32:0] exp_v;
        int base, mode;
        for (int i = 0; i < NR; i++) begin
            base   = int'($urandom_range(1, 254));
            r_a[i] = rand_op(base);
            mode   = int'($urandom_range(0, 7));
            if (mode == 0)      r_b[i] = r_a[i] ^ 32'h80000000;
            else if (mode == 1) r_b[i] = {~r_a[i][31], r_a[i][30:8], 8'($urandom)};
            else                r_b[i] = rand_op(base);
            r_ei[i] = ($urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < NR + 3; i++) begin
            if (i < NR) drive(r_a[i], r_b[i], r_ei[i]); else drive(32'h0, 32'h0, 1'b0);
            @(posedge CLK); #1;
            if (i >= 3) begin
                exp_v = ref_add(r_a[i-3], r_b[i-3], r_ei[i-3]);
                checks++;
                if (result !== exp_v[31:0] || exce_out !== exp_v[32]) begin
                    errors++;
                    $display("FAIL random[%0d] %h+%h ei %b: result %h exce %b, required %h exce %b",
                             i - 3, r_a[i-3], r_b[i-3], r_ei[i-3], result, exce_out, exp_v[31:0], exp_v[32]);
                end
            end
        end
    endtask

    initial begin
        set_dir(0,  32'h3F600000, 32'h3F700000, 1'b0, 32'h3FE80000, 1'b0);
        set_dir(1,  32'h41E00000, 32'h00000000, 1'b0, 32'h41E00000, 1'b0);
        set_dir(2,  32'h43E00000, 32'h41E00000, 1'b1, 32'h43EE0000, 1'b1);
        set_dir(3,  32'hC3E00000, 32'h41E00000, 1'b0, 32'hC3D20000, 1'b0);
        set_dir(4,  32'h47E00000, 32'h47E00000, 1'b0, 32'h48600000, 1'b0);
        set_dir(5,  32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 1'b0);
        set_dir(6,  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);
        set_dir(7,  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1);
        set_dir(8,  32'h3F800000, 32'hFFC00000, 1'b0, 32'hFF800000, 1'b1);
        set_dir(9,  32'hFF800000, 32'h7F800001, 1'b0, 32'hFF800000, 1'b1);
        set_dir(10, 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0);
        set_dir(11, 32'h00C00000, 32'h80800000, 1'b0, 32'h00000000, 1'b0);
        set_dir(12, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0);
        set_dir(13, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0);
        set_dir(14, 32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 1'b1);
        set_dir(15, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0);
        set_dir(16, 32'h3F800000, 32'h3F800000, 1'b1, 32'h40000000, 1'b1);

        test_reset();
        test_directed();
        test_back_to_back();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
